// File: rtl/cache_dm_param.sv
// cache_dm_param: direct-mapped cache of one-word lines between a requester and a word-addressed RAM.
// Latency: a read hit (and a write hit in write-back builds) is busy for 1 cycle; each RAM phase adds a round trip.
// Backpressure: response=1 while busy; req/mode/address/data are ignored until response returns to 0.
// Build option: define CACHE_WB_EN for write-back with write-allocate; otherwise write-through, no write-allocate.
module cache_dm_param #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 12,
   parameter int INDEX_W = 6,
   parameter int CNT_W   = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              mode,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] data,
   output logic              response,
   output logic [DATA_W-1:0] out,
   output logic              hit,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic              ram_req,
   output logic              ram_mode,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   input  logic              ram_done,
   input  logic [DATA_W-1:0] ram_out
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = ADDR_W - INDEX_W;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_COMPARE   = 3'd1;
`ifdef CACHE_WB_EN
   localparam logic [2:0] S_EVICT     = 3'd2;
`endif
   localparam logic [2:0] S_FILL      = 3'd3;
   localparam logic [2:0] S_WRITE_RAM = 3'd4;

   logic [2:0]        state_q;
   logic              mode_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              response_q;
   logic [DATA_W-1:0] out_q;
   logic              hit_q;
   logic [CNT_W-1:0]  hit_count_q;
   logic [CNT_W-1:0]  miss_count_q;
   logic              ram_req_q;
   logic              ram_mode_q;
   logic [ADDR_W-1:0] ram_address_q;
   logic [DATA_W-1:0] ram_data_q;

   logic [DATA_W-1:0] line_data_q [LINES];
   logic [TAG_W-1:0]  line_tag_q  [LINES];
   logic [LINES-1:0]  valid_q;
`ifdef CACHE_WB_EN
   logic [LINES-1:0]  dirty_q;
`endif

   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic               lookup_hit;
   logic               done_ok;
   logic               line_we;
   logic [DATA_W-1:0]  line_wdata;

   assign idx        = addr_q[INDEX_W-1:0];
   assign tag        = addr_q[ADDR_W-1:INDEX_W];
   assign lookup_hit = valid_q[idx] && (line_tag_q[idx] == tag);
   // The completion pulse only counts once the command strobe has dropped.
   assign done_ok    = ram_done && !ram_req_q;

   // Line write port: write hits in COMPARE, refills when the FILL read returns.
   always_comb begin
      line_we    = 1'b0;
      line_wdata = wdata_q;
      case (state_q)
         S_COMPARE: line_we = mode_q && lookup_hit;
         S_FILL: begin
            line_we = done_ok;
`ifdef CACHE_WB_EN
            // A write miss allocates, then merges the write word over the refill.
            line_wdata = mode_q ? wdata_q : ram_out;
`else
            line_wdata = ram_out;
`endif
         end
         default: line_we = 1'b0;
      endcase
   end

   // Line data and tag storage; contents are qualified by valid_q so no reset is needed.
   always_ff @(posedge clk) begin
      if (line_we) begin
         line_data_q[idx] <= line_wdata;
         line_tag_q[idx]  <= tag;
      end
   end

   // Access sequencer: capture, lookup, RAM phases, status and counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         mode_q        <= 1'b0;
         addr_q        <= '0;
         wdata_q       <= '0;
         response_q    <= 1'b0;
         out_q         <= '0;
         hit_q         <= 1'b0;
         hit_count_q   <= '0;
         miss_count_q  <= '0;
         ram_req_q     <= 1'b0;
         ram_mode_q    <= 1'b0;
         ram_address_q <= '0;
         ram_data_q    <= '0;
         valid_q       <= '0;
`ifdef CACHE_WB_EN
         dirty_q       <= '0;
`endif
      end else begin
         // The command strobe lasts exactly one cycle.
         ram_req_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (req) begin
                  mode_q     <= mode;
                  addr_q     <= address;
                  wdata_q    <= data;
                  response_q <= 1'b1;
                  state_q    <= S_COMPARE;
               end
            end
            S_COMPARE: begin
               hit_q <= lookup_hit;
               if (lookup_hit) begin
                  if (hit_count_q != {CNT_W{1'b1}}) hit_count_q <= hit_count_q + CNT_W'(1);
               end else begin
                  if (miss_count_q != {CNT_W{1'b1}}) miss_count_q <= miss_count_q + CNT_W'(1);
               end
               if (lookup_hit && !mode_q) begin
                  out_q      <= line_data_q[idx];
                  response_q <= 1'b0;
                  state_q    <= S_IDLE;
`ifdef CACHE_WB_EN
               end else if (lookup_hit) begin
                  dirty_q[idx] <= 1'b1;
                  response_q   <= 1'b0;
                  state_q      <= S_IDLE;
               end else if (valid_q[idx] && dirty_q[idx]) begin
                  // Write the displaced dirty word back to its own address first.
                  ram_req_q     <= 1'b1;
                  ram_mode_q    <= 1'b1;
                  ram_address_q <= {line_tag_q[idx], idx};
                  ram_data_q    <= line_data_q[idx];
                  state_q       <= S_EVICT;
               end else begin
                  ram_req_q     <= 1'b1;
                  ram_mode_q    <= 1'b0;
                  ram_address_q <= addr_q;
                  ram_data_q    <= wdata_q;
                  state_q       <= S_FILL;
               end
`else
               end else if (mode_q) begin
                  ram_req_q     <= 1'b1;
                  ram_mode_q    <= 1'b1;
                  ram_address_q <= addr_q;
                  ram_data_q    <= wdata_q;
                  state_q       <= S_WRITE_RAM;
               end else begin
                  ram_req_q     <= 1'b1;
                  ram_mode_q    <= 1'b0;
                  ram_address_q <= addr_q;
                  ram_data_q    <= wdata_q;
                  state_q       <= S_FILL;
               end
`endif
            end
`ifdef CACHE_WB_EN
            S_EVICT: begin
               if (done_ok) begin
                  ram_req_q     <= 1'b1;
                  ram_mode_q    <= 1'b0;
                  ram_address_q <= addr_q;
                  ram_data_q    <= wdata_q;
                  state_q       <= S_FILL;
               end
            end
`endif
            S_FILL: begin
               if (done_ok) begin
                  valid_q[idx] <= 1'b1;
`ifdef CACHE_WB_EN
                  dirty_q[idx] <= mode_q;
`endif
                  if (!mode_q) out_q <= ram_out;
                  response_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            S_WRITE_RAM: begin
               if (done_ok) begin
                  response_q <= 1'b0;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               response_q <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign response    = response_q;
   assign out         = out_q;
   assign hit         = hit_q;
   assign hit_count   = hit_count_q;
   assign miss_count  = miss_count_q;
   assign ram_req     = ram_req_q;
   assign ram_mode    = ram_mode_q;
   assign ram_address = ram_address_q;
   assign ram_data    = ram_data_q;

endmodule

// File: tb/tb_cache_dm_param.sv
// tb_cache_dm_param: randomized accesses against a line-level cache model and a RAM responder.
// Latency: RAM responds 1-4 cycles after each command, with optional spurious pulses in the strobe cycle.
// Backpressure: inputs are scrambled while the cache is busy; they must have no effect.
module tb_cache_dm_param;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 12;
   localparam int INDEX_W = 6;
   localparam int CNT_W   = 4;
   localparam int LINES   = 1 << INDEX_W;
   localparam int DEPTH   = 1 << ADDR_W;
   localparam int TAG_W   = ADDR_W - INDEX_W;
   localparam int MAXC    = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              req = 1'b0;
   logic              mode = 1'b0;
   logic [ADDR_W-1:0] address = '0;
   logic [DATA_W-1:0] data = '0;
   logic              response;
   logic [DATA_W-1:0] out;
   logic              hit;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;
   logic              ram_req;
   logic              ram_mode;
   logic [ADDR_W-1:0] ram_address;
   logic [DATA_W-1:0] ram_data;
   logic              ram_done = 1'b0;
   logic [DATA_W-1:0] ram_out = '0;

   always #5 clk = ~clk;

   cache_dm_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .address(address), .data(data),
      .response(response), .out(out), .hit(hit), .hit_count(hit_count), .miss_count(miss_count),
      .ram_req(ram_req), .ram_mode(ram_mode), .ram_address(ram_address), .ram_data(ram_data),
      .ram_done(ram_done), .ram_out(ram_out)
   );

   typedef struct packed {
      logic              m;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } cmd_t;

   cmd_t got_q[$];
   cmd_t exp_q[$];
   logic [DATA_W-1:0] ram_mem [DEPTH];
   logic [DATA_W-1:0] ref_mem [DEPTH];
   int                pend_lat  = 0;
   logic [DATA_W-1:0] pend_data = '0;
   bit                spur_en   = 1'b0;
   int                fixed_lat = 0;

   int checks = 0;
   int errors = 0;

   // Reference cache: plain per-line arrays updated by the access rules.
   bit                m_valid [LINES];
   bit                m_dirty [LINES];
   logic [TAG_W-1:0]  m_tag   [LINES];
   logic [DATA_W-1:0] m_data  [LINES];
   logic [DATA_W-1:0] m_out;
   bit                m_hit;
   int                m_hits, m_misses;

   // RAM responder: logs each strobe, answers after a delay, optionally pulses early.
   initial begin : responder
      cmd_t c;
      forever begin
         @(negedge clk);
         ram_done = 1'b0;
         if (pend_lat > 0) begin
            pend_lat--;
            if (pend_lat == 0) begin
               ram_done = 1'b1;
               ram_out  = pend_data;
            end
         end
         if (ram_req === 1'b1) begin
            c.m = ram_mode; c.a = ram_address; c.d = ram_data;
            got_q.push_back(c);
            if (ram_mode) ram_mem[ram_address] = ram_data;
            pend_data = ram_mode ? DATA_W'($urandom) : ram_mem[ram_address];
            pend_lat  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 4));
            if (spur_en) begin
               ram_done = 1'b1;
               ram_out  = DATA_W'($urandom);
            end
         end
      end
   end

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
      m_out = '0; m_hit = 1'b0; m_hits = 0; m_misses = 0;
   endtask

   task automatic model_access(input bit wr, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, output bit fast);
      int idx;
      logic [TAG_W-1:0] tg;
      cmd_t c;
      bit h;
      idx = int'(a) % LINES;
      tg  = TAG_W'(int'(a) / LINES);
      h   = m_valid[idx] && (m_tag[idx] == tg);
      m_hit = h;
      if (h) m_hits = (m_hits < MAXC) ? m_hits + 1 : MAXC;
      else   m_misses = (m_misses < MAXC) ? m_misses + 1 : MAXC;
      fast = 1'b0;
`ifdef CACHE_WB_EN
      if (h && !wr) begin
         m_out = m_data[idx]; fast = 1'b1;
      end else if (h) begin
         m_data[idx] = d; m_dirty[idx] = 1'b1; fast = 1'b1;
      end else begin
         if (m_valid[idx] && m_dirty[idx]) begin
            c.m = 1'b1; c.a = ADDR_W'(int'(m_tag[idx]) * LINES + idx); c.d = m_data[idx];
            exp_q.push_back(c);
            ref_mem[c.a] = c.d;
         end
         c.m = 1'b0; c.a = a; c.d = '0;
         exp_q.push_back(c);
         m_valid[idx] = 1'b1; m_tag[idx] = tg;
         if (wr) begin
            m_data[idx] = d; m_dirty[idx] = 1'b1;
         end else begin
            m_data[idx] = ref_mem[a]; m_dirty[idx] = 1'b0; m_out = ref_mem[a];
         end
      end
`else
      if (h && !wr) begin
         m_out = m_data[idx]; fast = 1'b1;
      end else if (wr) begin
         if (h) m_data[idx] = d;
         c.m = 1'b1; c.a = a; c.d = d;
         exp_q.push_back(c);
         ref_mem[a] = d;
      end else begin
         c.m = 1'b0; c.a = a; c.d = '0;
         exp_q.push_back(c);
         m_valid[idx] = 1'b1; m_tag[idx] = tg;
         m_data[idx] = ref_mem[a]; m_out = ref_mem[a];
      end
`endif
   endtask

   // One access end to end, compared against the model afterwards.
   task automatic do_access(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit fast, fin;
      int cyc;
      cmd_t g;
      exp_q.delete();
      got_q.delete();
      model_access(wr, a, d, fast);
      @(negedge clk);
      req = 1'b1; mode = wr; address = a; data = d;
      @(negedge clk);
      checks++;
      if (response !== 1'b1) begin errors++; $display("FAIL resp_rise addr=%h got=%b exp=1", a, response); end
      cyc = 0; fin = 1'b0;
      while (!fin) begin
         if (response !== 1'b1 || cyc >= 200) fin = 1'b1;
         else begin
            cyc++;
            req = 1'($urandom); mode = 1'($urandom);
            address = ADDR_W'($urandom); data = DATA_W'($urandom);
            @(negedge clk);
         end
      end
      req = 1'b0;
      checks++;
      if (cyc >= 200) begin errors++; $display("FAIL timeout addr=%h got=%0d cycles exp<200", a, cyc); end
      checks++;
      if (out !== m_out) begin errors++; $display("FAIL out addr=%h got=%h exp=%h", a, out, m_out); end
      checks++;
      if (hit !== m_hit) begin errors++; $display("FAIL hit addr=%h got=%b exp=%b", a, hit, m_hit); end
      checks++;
      if (hit_count !== CNT_W'(m_hits)) begin errors++; $display("FAIL hit_count got=%0d exp=%0d", hit_count, m_hits); end
      checks++;
      if (miss_count !== CNT_W'(m_misses)) begin errors++; $display("FAIL miss_count got=%0d exp=%0d", miss_count, m_misses); end
      if (fast) begin
         checks++;
         if (cyc !== 1) begin errors++; $display("FAIL busy_len addr=%h got=%0d exp=1", a, cyc); end
      end
      checks++;
      if (got_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL ram_cmd_count addr=%h got=%0d exp=%0d", a, got_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            g = got_q[i];
            if (!g.m) g.d = '0;
            checks++;
            if (g !== exp_q[i]) begin
               errors++; $display("FAIL ram_cmd[%0d] got=%b/%h/%h exp=%b/%h/%h", i, g.m, g.a, g.d,
                                  exp_q[i].m, exp_q[i].a, exp_q[i].d);
            end
         end
      end
   endtask

   task automatic apply_reset(input bit keep_pending);
      @(negedge clk);
      rst_n = 1'b0;
      if (!keep_pending) pend_lat = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      got_q.delete();
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({response, out, hit, hit_count, miss_count, ram_req, ram_mode, ram_address, ram_data} !== '0) begin
         errors++; $display("FAIL reset_outputs got resp=%b out=%h hit=%b hc=%0d mc=%0d rq=%b exp all zero",
                            response, out, hit, hit_count, miss_count, ram_req);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_read_fill_hit();
      do_access(1'b0, 12'h005, '0);
      checks++;
      if (out !== 32'hA5 || hit !== 1'b0 || miss_count !== 4'd1) begin
         errors++; $display("FAIL fill_005 got out=%h hit=%b mc=%0d exp out=a5 hit=0 mc=1", out, hit, miss_count);
      end
      do_access(1'b0, 12'h005, '0);
      checks++;
      if (hit !== 1'b1 || hit_count !== 4'd1 || got_q.size() != 0) begin
         errors++; $display("FAIL rehit_005 got hit=%b hc=%0d cmds=%0d exp 1/1/0", hit, hit_count, got_q.size());
      end
   endtask

   task automatic test_conflict();
      do_access(1'b0, 12'h045, '0);
      checks++;
      if (hit !== 1'b0 || got_q.size() != 1 || got_q[0].a !== 12'h045) begin
         errors++; $display("FAIL conflict_045 got hit=%b cmds=%0d exp hit=0 one read of 045", hit, got_q.size());
      end
      do_access(1'b0, 12'h005, '0);
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL conflict_005 got hit=%b exp=0", hit); end
   endtask

`ifdef CACHE_WB_EN
   task automatic test_wb_evict();
      apply_reset(1'b0);
      do_access(1'b1, 12'h007, 32'hBEEF);
      do_access(1'b0, 12'h047, '0);
      checks++;
      if (got_q.size() != 2 || got_q[0].m !== 1'b1 || got_q[0].a !== 12'h007 || got_q[0].d !== 32'hBEEF ||
          got_q[1].m !== 1'b0 || got_q[1].a !== 12'h047) begin
         errors++; $display("FAIL wb_evict got cmds=%0d exp write 007=beef then read 047", got_q.size());
      end
   endtask
`else
   task automatic test_write_through();
      apply_reset(1'b0);
      do_access(1'b1, 12'h010, 32'h1234);
      checks++;
      if (got_q.size() != 1 || got_q[0].m !== 1'b1 || got_q[0].d !== 32'h1234) begin
         errors++; $display("FAIL wt_write got cmds=%0d exp one write of 1234", got_q.size());
      end
      do_access(1'b0, 12'h010, '0);
      checks++;
      if (hit !== 1'b0 || out !== 32'h1234) begin
         errors++; $display("FAIL wt_readback got hit=%b out=%h exp hit=0 out=1234", hit, out);
      end
   endtask
`endif

   task automatic test_mid_reset();
      int w;
      apply_reset(1'b0);
      fixed_lat = 6;
      got_q.delete();
      @(negedge clk);
      req = 1'b1; mode = 1'b0; address = 12'h005;
      @(negedge clk);
      req = 1'b0;
      w = 0;
      while (got_q.size() == 0 && w < 20) begin @(negedge clk); w++; end
      checks++;
      if (got_q.size() == 0) begin errors++; $display("FAIL mid_reset_fill got no ram_req exp one"); end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (response !== 1'b0 || ram_req !== 1'b0 || out !== '0) begin
         errors++; $display("FAIL mid_reset_now got resp=%b rq=%b out=%h exp 0/0/0", response, ram_req, out);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (response !== 1'b0 || out !== '0 || miss_count !== '0 || hit_count !== '0) begin
         errors++; $display("FAIL late_done got resp=%b out=%h mc=%0d hc=%0d exp all zero",
                            response, out, miss_count, hit_count);
      end
      fixed_lat = 0;
      model_reset();
      do_access(1'b0, 12'h005, '0);
      checks++;
      if (hit !== 1'b0) begin errors++; $display("FAIL reread_after_reset got hit=%b exp=0", hit); end
   endtask

   task automatic test_saturation();
      apply_reset(1'b0);
      for (int i = 0; i < 20; i++) do_access(1'b0, (i % 2 == 0) ? 12'h005 : 12'h045, '0);
      for (int i = 0; i < 20; i++) do_access(1'b0, 12'h045, '0);
      checks++;
      if (hit_count !== 4'hF || miss_count !== 4'hF) begin
         errors++; $display("FAIL saturate got hc=%0d mc=%0d exp 15/15", hit_count, miss_count);
      end
   endtask

   task automatic test_random();
      logic [ADDR_W-1:0] a;
      apply_reset(1'b0);
      for (int i = 0; i < 150; i++) begin
         spur_en = 1'($urandom);
         a = ADDR_W'((int'($urandom_range(0, 3)) << INDEX_W) | int'($urandom_range(0, 7)));
         do_access(1'($urandom), a, DATA_W'($urandom));
      end
      spur_en = 1'b0;
   endtask

   initial begin
      logic [DATA_W-1:0] v;
      for (int i = 0; i < DEPTH; i++) begin
         v = DATA_W'($urandom);
         ram_mem[i] = v;
         ref_mem[i] = v;
      end
      ram_mem[12'h005] = 32'hA5;
      ref_mem[12'h005] = 32'hA5;
      test_reset();
      test_read_fill_hit();
      test_conflict();
`ifdef CACHE_WB_EN
      test_wb_evict();
`else
      test_write_through();
`endif
      test_mid_reset();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
